// File: rtl/dmd_frame_loader.sv
// Parses the UART byte stream into 4-bit pixels for the DMD back buffer
// and hands finished frames to the video generator with a tear-free flip.
module dmd_frame_loader #(
  parameter int         COLS        = 128,
  parameter int         ROWS        = 32,
  parameter int         ADDR_W      = 13,
  parameter int         TIMEOUT_CYC = 4000000,
  parameter logic [7:0] SOF_BYTE    = 8'h46,
  parameter logic [7:0] CLR_BYTE    = 8'h43
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              wr_en,
  output logic              wr_sel,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [3:0]        wr_data,
  output logic              front_sel,
  output logic              flip_req,
  input  logic              flip_ack,
  output logic              busy,
  output logic              frame_done,
  output logic              err_timeout,
  output logic              err_overrun
);

  localparam int NPIX  = COLS * ROWS;
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(NPIX - 1);
  localparam logic [CNT_W-1:0]  TO_LAST  = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    WR_HI,
    WR_LO,
    CLEAR,
    WAIT_FLIP
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [7:0]        byte_q, byte_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [3:0]        wr_data_q, wr_data_d;
  logic              front_q, front_d;
  logic              done_q, done_d;
  logic              err_to_q, err_to_d;
  logic              err_ov_q, err_ov_d;
  logic              no_rx_st;

  // States that cannot take a byte; anything arriving there is an overrun.
  assign no_rx_st = (state_q == WR_HI) || (state_q == WR_LO) ||
                    (state_q == CLEAR) || (state_q == WAIT_FLIP);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    byte_d    = byte_q;
    cnt_d     = '0;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    front_d   = front_q;
    done_d    = 1'b0;
    err_to_d  = err_to_q;
    err_ov_d  = err_ov_q;

    unique case (state_q)
      IDLE: begin
        if (rx_valid && rx_data == SOF_BYTE) begin
          state_d  = RECV;
          idx_d    = '0;
          err_to_d = 1'b0;
          err_ov_d = 1'b0;
        end else if (rx_valid && rx_data == CLR_BYTE) begin
          state_d  = CLEAR;
          idx_d    = '0;
          err_to_d = 1'b0;
          err_ov_d = 1'b0;
        end
      end
      RECV: begin
        if (rx_valid) begin
          byte_d  = rx_data;
          state_d = WR_HI;
        end else if (cnt_q == TO_LAST) begin
          err_to_d = 1'b1;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WR_HI: begin
        wr_en_d   = 1'b1;
        wr_addr_d = idx_q;
        wr_data_d = byte_q[7:4];
        idx_d     = idx_q + 1'b1;
        state_d   = WR_LO;
      end
      WR_LO: begin
        wr_en_d   = 1'b1;
        wr_addr_d = idx_q;
        wr_data_d = byte_q[3:0];
        idx_d     = idx_q + 1'b1;
        state_d   = (idx_q == LAST_PIX) ? WAIT_FLIP : RECV;
      end
      CLEAR: begin
        wr_en_d   = 1'b1;
        wr_addr_d = idx_q;
        wr_data_d = 4'h0;
        idx_d     = idx_q + 1'b1;
        if (idx_q == LAST_PIX) state_d = WAIT_FLIP;
      end
      WAIT_FLIP: begin
        if (flip_ack) begin
          front_d = ~front_q;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (rx_valid && no_rx_st) err_ov_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      byte_q    <= '0;
      cnt_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      front_q   <= 1'b0;
      done_q    <= 1'b0;
      err_to_q  <= 1'b0;
      err_ov_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      byte_q    <= byte_d;
      cnt_q     <= cnt_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      front_q   <= front_d;
      done_q    <= done_d;
      err_to_q  <= err_to_d;
      err_ov_q  <= err_ov_d;
    end
  end

  assign wr_en       = wr_en_q;
  assign wr_sel      = ~front_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign front_sel   = front_q;
  assign flip_req    = (state_q == WAIT_FLIP);
  assign busy        = (state_q != IDLE);
  assign frame_done  = done_q;
  assign err_timeout = err_to_q;
  assign err_overrun = err_ov_q;

endmodule

// File: tb/tb_dmd_frame_loader.sv
// Randomized bench for dmd_frame_loader: a byte-acceptance model predicts
// every pixel write, flip handshake, and error flag.
module tb_dmd_frame_loader;

  localparam int TO   = 300;
  localparam int NPIX = 4096;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        flip_ack = 1'b0;
  logic        wr_en, wr_sel, front_sel, flip_req;
  logic        busy, frame_done, err_timeout, err_overrun;
  logic [12:0] wr_addr;
  logic [3:0]  wr_data;

  dmd_frame_loader #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .wr_en(wr_en), .wr_sel(wr_sel),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .front_sel(front_sel), .flip_req(flip_req),
    .flip_ack(flip_ack), .busy(busy),
    .frame_done(frame_done),
    .err_timeout(err_timeout),
    .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        sel;
    logic [12:0] addr;
    logic [3:0]  data;
  } wr_t;

  wr_t        wq[$];
  wr_t        mon_w;
  logic [3:0] exp_pix [NPIX];
  int         n_cmp = 0;
  int         n_bad = 0;

  always @(negedge clk) begin
    if (rst_n && wr_en) begin
      mon_w.sel  = wr_sel;
      mon_w.addr = wr_addr;
      mon_w.data = wr_data;
      wq.push_back(mon_w);
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got no finish, want finish by 2ms");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic pulse_ack();
    flip_ack = 1'b1;
    tick();
    flip_ack = 1'b0;
  endtask

  // Number of the first n captured writes that differ from the model.
  function automatic int count_bad(input int n, input logic sel,
                                   output int first);
    int bad = 0;
    first = -1;
    for (int i = 0; i < n; i++) begin
      if (i >= wq.size() || wq[i].sel !== sel ||
          wq[i].addr !== 13'(i) || wq[i].data !== exp_pix[i]) begin
        bad++;
        if (first < 0) first = i;
      end
    end
    return bad;
  endfunction

  task automatic wait_flip(input int limit);
    int w = 0;
    while (flip_req !== 1'b1 && w < limit) begin
      tick();
      w++;
    end
    n_cmp++;
    if (flip_req !== 1'b1) begin
      n_bad++;
      $display("FAIL flip_req_wait: got %b after %0d cycles, want 1",
               flip_req, w);
    end
    idle(1);
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    flip_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({front_sel, wr_sel, flip_req, wr_en, busy} !== 5'b01000) begin
      n_bad++;
      $display("FAIL reset_ctl: got %b want 01000",
               {front_sel, wr_sel, flip_req, wr_en, busy});
    end
    n_cmp++;
    if ({frame_done, err_timeout, err_overrun, wr_addr, wr_data}
        !== 20'h0) begin
      n_bad++;
      $display("FAIL reset_out: got %h want 0",
               {frame_done, err_timeout, err_overrun, wr_addr, wr_data});
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_frame_fixed();
    int bad, first;
    wq.delete();
    send(8'h46);
    for (int i = 0; i < 2048; i++) begin
      send(8'h3C);
      idle(2);
    end
    for (int i = 0; i < NPIX; i++) exp_pix[i] = i[0] ? 4'hC : 4'h3;
    wait_flip(10);
    bad = count_bad(NPIX, 1'b1, first);
    n_cmp++;
    if (bad !== 0 || wq.size() !== NPIX) begin
      n_bad++;
      $display("FAIL frame_writes: got %0d bad of %0d (first %0d), want 0 of 4096",
               bad, wq.size(), first);
    end
    n_cmp++;
    if (err_overrun !== 1'b0) begin
      n_bad++;
      $display("FAIL frame_ovr: got %b want 0", err_overrun);
    end
    pulse_ack();
    n_cmp++;
    if ({front_sel, wr_sel, frame_done, flip_req, busy} !== 5'b10100) begin
      n_bad++;
      $display("FAIL frame_flip: got %b want 10100",
               {front_sel, wr_sel, frame_done, flip_req, busy});
    end
    tick();
    n_cmp++;
    if (frame_done !== 1'b0) begin
      n_bad++;
      $display("FAIL frame_done_pulse: got %b want 0", frame_done);
    end
  endtask

  task automatic test_clear();
    int bad, first;
    wq.delete();
    send(8'h43);
    for (int i = 0; i < NPIX; i++) exp_pix[i] = 4'h0;
    wait_flip(4200);
    bad = count_bad(NPIX, 1'b0, first);
    n_cmp++;
    if (bad !== 0 || wq.size() !== NPIX) begin
      n_bad++;
      $display("FAIL clear_writes: got %0d bad of %0d (first %0d), want 0 of 4096",
               bad, wq.size(), first);
    end
    pulse_ack();
    n_cmp++;
    if ({front_sel, frame_done, flip_req} !== 3'b010) begin
      n_bad++;
      $display("FAIL clear_flip: got %b want 010",
               {front_sel, frame_done, flip_req});
    end
  endtask

  task automatic test_timeout();
    int bad, first;
    logic [7:0] b;
    wq.delete();
    send(8'h46);
    for (int i = 0; i < 10; i++) begin
      b = 8'($urandom);
      exp_pix[2*i]   = b[7:4];
      exp_pix[2*i+1] = b[3:0];
      send(b);
      idle(2);
    end
    idle(TO / 2);
    n_cmp++;
    if ({err_timeout, busy} !== 2'b01) begin
      n_bad++;
      $display("FAIL to_early: got %b want 01", {err_timeout, busy});
    end
    idle(TO);
    n_cmp++;
    if ({err_timeout, busy, flip_req} !== 3'b100) begin
      n_bad++;
      $display("FAIL to_abort: got %b want 100",
               {err_timeout, busy, flip_req});
    end
    bad = count_bad(20, 1'b1, first);
    n_cmp++;
    if (bad !== 0 || wq.size() !== 20) begin
      n_bad++;
      $display("FAIL to_writes: got %0d bad of %0d (first %0d), want 0 of 20",
               bad, wq.size(), first);
    end
    send(8'h46);
    n_cmp++;
    if ({err_timeout, busy} !== 2'b01) begin
      n_bad++;
      $display("FAIL to_clear: got %b want 01", {err_timeout, busy});
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    int acc = 0, t = 0, ready = 0, bad, first;
    bit dropped = 0, v;
    logic [7:0] b;
    wq.delete();
    send(8'h46);
    while (acc < 2047) begin
      v = (t < 2) || ($urandom_range(0, 1) == 1);
      if (v) begin
        b = 8'($urandom);
        if (t >= ready) begin
          exp_pix[2*acc]   = b[7:4];
          exp_pix[2*acc+1] = b[3:0];
          acc++;
          ready = t + 3;
        end else begin
          dropped = 1;
        end
        send(b);
      end else begin
        idle(1);
      end
      t++;
    end
    idle(3);
    n_cmp++;
    if (flip_req !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_early_flip: got %b want 0", flip_req);
    end
    b = 8'($urandom);
    exp_pix[4094] = b[7:4];
    exp_pix[4095] = b[3:0];
    send(b);
    wait_flip(10);
    bad = count_bad(NPIX, 1'b1, first);
    n_cmp++;
    if (bad !== 0 || wq.size() !== NPIX) begin
      n_bad++;
      $display("FAIL b2b_writes: got %0d bad of %0d (first %0d), want 0 of 4096",
               bad, wq.size(), first);
    end
    n_cmp++;
    if (err_overrun !== 1'(dropped)) begin
      n_bad++;
      $display("FAIL b2b_ovr: got %b want %b", err_overrun, dropped);
    end
    pulse_ack();
    n_cmp++;
    if ({front_sel, frame_done} !== 2'b11) begin
      n_bad++;
      $display("FAIL b2b_flip: got %b want 11", {front_sel, frame_done});
    end
  endtask

  task automatic test_ignored();
    wq.delete();
    send(8'h00);
    idle(2);
    n_cmp++;
    if ({busy, flip_req} !== 2'b00 || wq.size() !== 0) begin
      n_bad++;
      $display("FAIL ign_byte: got busy/req %b writes %0d, want 00 and 0",
               {busy, flip_req}, wq.size());
    end
    pulse_ack();
    tick();
    n_cmp++;
    if ({front_sel, frame_done, busy} !== 3'b100) begin
      n_bad++;
      $display("FAIL ign_ack: got %b want 100",
               {front_sel, frame_done, busy});
    end
    send(8'h46);
    send(8'h5A);
    idle(4);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL ign_recv: got busy %b want 1", busy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, front_sel, wr_sel, wr_en} !== 4'b0010) begin
      n_bad++;
      $display("FAIL async_rst: got %b want 0010",
               {busy, front_sel, wr_sel, wr_en});
    end
    tick();
    rst_n = 1'b1;
    idle(3);
    n_cmp++;
    if ({busy, front_sel, flip_req} !== 3'b000) begin
      n_bad++;
      $display("FAIL post_rst: got %b want 000",
               {busy, front_sel, flip_req});
    end
  endtask

  initial begin
    test_reset();
    test_frame_fixed();
    test_clear();
    test_timeout();
    test_back_to_back();
    test_ignored();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
